// File: rtl/led_pwm_fader.sv
// PWM LED output stage: linearly fades brightness between off and full-on
// following an enable/target request, with busy/done ramp status.
module led_pwm_fader #(
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned STEP_CYCLES = 97_656
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                enable,
    input  logic                target,
    output logic [PWM_BITS-1:0] level,
    output logic                pwm_out,
    output logic                busy,
    output logic                done
);

    localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PWM_BITS-1:0] MAX_LEVEL = '1;
    localparam logic [PWM_BITS-1:0] PWM_LAST  = MAX_LEVEL - PWM_BITS'(1);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_OFF       = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_ON        = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_e;

    state_e              state_q;
    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [STEP_W-1:0]   step_cnt_q;
    logic                pwm_out_q;
    logic                busy_q;
    logic                done_q;

    logic go_c;
    logic step_tc_c;

    assign go_c      = enable & target;
    assign step_tc_c = (step_cnt_q == STEP_LAST);

    // A direction change always wins over a coincident terminal step.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_OFF;
            level_q    <= '0;
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            pwm_out_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_BITS'(1);
            pwm_out_q <= (pwm_cnt_q < level_q);
            done_q    <= 1'b0;

            case (state_q)
                S_OFF: begin
                    if (go_c) begin
                        state_q    <= S_RAMP_UP;
                        busy_q     <= 1'b1;
                        step_cnt_q <= '0;
                    end
                end
                S_ON: begin
                    if (!go_c) begin
                        state_q    <= S_RAMP_DOWN;
                        busy_q     <= 1'b1;
                        step_cnt_q <= '0;
                    end
                end
                S_RAMP_UP: begin
                    if (!go_c) begin
                        state_q    <= S_RAMP_DOWN;
                        step_cnt_q <= '0;
                    end else if (step_tc_c) begin
                        step_cnt_q <= '0;
                        if (level_q != MAX_LEVEL) begin
                            level_q <= level_q + PWM_BITS'(1);
                        end
                        if (level_q >= PWM_LAST) begin
                            state_q <= S_ON;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_q + STEP_W'(1);
                    end
                end
                S_RAMP_DOWN: begin
                    if (go_c) begin
                        state_q    <= S_RAMP_UP;
                        step_cnt_q <= '0;
                    end else if (step_tc_c) begin
                        step_cnt_q <= '0;
                        if (level_q != '0) begin
                            level_q <= level_q - PWM_BITS'(1);
                        end
                        if (level_q <= PWM_BITS'(1)) begin
                            state_q <= S_OFF;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_q + STEP_W'(1);
                    end
                end
                default: begin
                    state_q <= S_OFF;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign level   = level_q;
    assign pwm_out = pwm_out_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
